// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed by the bit counter for a given operand width.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and operand/result bundle for serial_adder_ctrl.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, sum, c_out
    );
`else
    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
`endif

endinterface

// File: rtl/bit_adder_cell.sv
// Combinational 1-bit full adder reused once per bit by the serial sequencer.
module bit_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one full-adder cell iterated LSB first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b via ~b and carry-in 1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              step;
    logic              last_bit;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  res_sh;
    logic [WIDTH-1:0]  res_next;
    logic              carry;
    logic [CW-1:0]     count;

    logic [WIDTH-1:0]  b_load;
    logic              carry_load;
    logic              cell_s;
    logic              cell_co;

    logic [WIDTH-1:0]  sum_q;
    logic              c_out_q;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and force the initial carry to 1.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub | bus.c_in;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.c_in;
`endif

    bit_adder_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last_bit = (count == LAST_BIT);

    // New bit enters at the MSB; also correct for WIDTH == 1.
    assign res_next = (res_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            count   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (load) begin
            a_sh   <= bus.a;
            b_sh   <= b_load;
            res_sh <= '0;
            carry  <= carry_load;
            count  <= '0;
        end else if (step) begin
            res_sh <= res_next;
            carry  <= cell_co;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            count  <= count + CW'(1);
            // Published outputs change only here, so partial sums never show.
            if (last_bit) begin
                sum_q   <= res_next;
                c_out_q <= cell_co;
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: vector table plus corner sequences.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c_in;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation from IDLE and observe 12 cycles after acceptance.
    // done_edge k means done was high going into the k-th edge after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co,
                          output int done_edge, output int done_cnt, output int busy_cnt);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
        bus.start = 1'b1;
        @(posedge clk);
        done_edge = -1;
        done_cnt  = 0;
        busy_cnt  = 0;
        s  = '0;
        co = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = k;
                    s  = bus.sum;
                    co = bus.c_out;
                end
            end
        end
    endtask

    vec_t vecs [8];

    initial begin
        logic [W-1:0] s;
        logic         co;
        int           de, dc, bc;
        int           first_done, second_done;
        logic [W-1:0] first_sum, second_sum;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_cout", 32'(bus.c_out), 32'd0);
        rst_n = 1'b1;

        // Table-driven add vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c_in, s, co, de, dc, bc);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_done_edge", i), 32'(de), 32'd9);
            check($sformatf("vec%0d_done_count", i), 32'(dc), 32'd1);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd9);
        end

        // start pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        bus.a = 8'h22; bus.b = 8'h33; bus.c_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        dc = 0; s = '0; co = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 4) begin
                bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h11;
            end
            if (bus.done) begin
                dc++; s = bus.sum; co = bus.c_out;
            end
        end
        check("midrun_sum", 32'(s), 32'h55);
        check("midrun_cout", 32'(co), 32'd0);
        check("midrun_done_count", 32'(dc), 32'd1);
        check("midrun_idle_after", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of RUN aborts the add
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h01; bus.c_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.c_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) dc++;
        end
        check("abort_no_done", 32'(dc), 32'd0);
        run_op(8'h12, 8'h34, 1'b0, s, co, de, dc, bc);
        check("after_abort_sum", 32'(s), 32'h46);
        check("after_abort_edge", 32'(de), 32'd9);

        // start held high: back-to-back adds every WIDTH+2 cycles
        @(negedge clk);
        bus.a = 8'h01; bus.b = 8'h02; bus.c_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        first_done = -1; second_done = -1; dc = 0;
        first_sum = '0; second_sum = '0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.a = 8'h03; bus.b = 8'h04;
            end
            if (k == 11) bus.start = 1'b0;
            if (bus.done) begin
                dc++;
                if (first_done < 0) begin
                    first_done = k; first_sum = bus.sum;
                end else if (second_done < 0) begin
                    second_done = k; second_sum = bus.sum;
                end
            end
        end
        check("held_first_sum", 32'(first_sum), 32'h03);
        check("held_second_sum", 32'(second_sum), 32'h07);
        check("held_first_edge", 32'(first_done), 32'd9);
        check("held_spacing", 32'(second_done - first_done), 32'd10);
        check("held_done_count", 32'(dc), 32'd2);

`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, s, co, de, dc, bc);
        check("sub_10_01_sum", 32'(s), 32'h0F);
        check("sub_10_01_cout", 32'(co), 32'd1);
        run_op(8'h01, 8'h02, 1'b0, s, co, de, dc, bc);
        check("sub_01_02_sum", 32'(s), 32'hFF);
        check("sub_01_02_cout", 32'(co), 32'd0);
        run_op(8'h10, 8'h01, 1'b1, s, co, de, dc, bc);
        check("sub_cin_ignored_sum", 32'(s), 32'h0F);
        bus.sub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
